// File: rtl/cart_race_core.sv
// Multi-player lane-dodging game core.
// Random walls scroll down a ROWS x COLS field at a level-dependent rate.
// Each player steers one cart along the bottom row. The core detects hits
// and tracks lives and saturating BCD scores, and it sequences IDLE/RUN/OVER.
// Optional feature macro: BOMB_EN (field-clear charges with a status LED).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start             synchronous pulse, starts/restarts a game
//   level[2:0]        speed select (scroll period = BASE_PERIOD >> level, min 1)
//   btn_l, btn_r      per-player move levels (rising edge = one lane step)
//   bomb              field-clear request (BOMB_EN only)
//   field             wall bits, row r at [r*COLS +: COLS], row 0 = cart row
//   cart              one-hot cart lane per player
//   alive             per-player not-yet-eliminated flags
//   score             per-player BCD score, SCORE_DIGITS digits, digit 0 LSB
//   state             00 IDLE, 01 RUN, 10 OVER
//   bomb_led          bomb charges remain while running
module cart_race_core #(
    parameter int unsigned N_PLAYERS    = 2,
    parameter int unsigned COLS         = 8,
    parameter int unsigned ROWS         = 8,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SCORE_DIGITS = 3,
    parameter int unsigned BASE_PERIOD  = 25000000,
    parameter int unsigned SPACING      = 3,
    parameter int unsigned BOMBS        = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [2:0]                          level,
    input  logic [N_PLAYERS-1:0]                btn_l,
    input  logic [N_PLAYERS-1:0]                btn_r,
    input  logic                                bomb,
    output logic [ROWS*COLS-1:0]                field,
    output logic [N_PLAYERS*COLS-1:0]           cart,
    output logic [N_PLAYERS-1:0]                alive,
    output logic [N_PLAYERS*4*SCORE_DIGITS-1:0] score,
    output logic [1:0]                          state,
    output logic                                bomb_led
);

    localparam int unsigned SW = 4 * SCORE_DIGITS;
    localparam int unsigned FW = ROWS * COLS;
    localparam int unsigned DW = $clog2(BASE_PERIOD + 1);
    localparam int unsigned WW = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam int unsigned LW = 3;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [COLS-1:0] CENTRE = COLS'(1) << (COLS / 2);

    logic [1:0]                  state_n;
    logic [FW-1:0]               field_n;
    logic [N_PLAYERS*COLS-1:0]   cart_n;
    logic [N_PLAYERS-1:0]        alive_n;
    logic [N_PLAYERS*SW-1:0]     score_n;
    logic [N_PLAYERS*LW-1:0]     lives, lives_n;
    logic [DW-1:0]               cnt, cnt_n;
    logic [WW-1:0]               wc, wc_n;
    logic [15:0]                 lfsr, lfsr_n;
    logic [N_PLAYERS-1:0]        prev_l, prev_r;
    logic [N_PLAYERS-1:0]        rise_l_c, rise_r_c;
    logic [DW-1:0]               period_c;
    logic                        tick_c;
    logic [7:0]                  hole_c;
    logic [COLS-1:0]             top_c;
    logic                        bomb_fire_c;

    // Saturating BCD increment: all nines stays all nines.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < int'(SCORE_DIGITS); d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) r = v;
        return r;
    endfunction

    // Scroll period, clamped to at least one clock.
    always_comb begin
        period_c = DW'(BASE_PERIOD >> level);
        if (period_c == '0) period_c = DW'(1);
    end

    // ">=" keeps the divider from running past the target after a level increase.
    assign tick_c   = (state == ST_RUN) && (cnt >= period_c - DW'(1));
    assign rise_l_c = btn_l & ~prev_l;
    assign rise_r_c = btn_r & ~prev_r;

    // New top row: a full wall with one hole, or empty between walls.
    assign hole_c = lfsr[7:0] % 8'(COLS);
    assign top_c  = (wc == '0) ? ~(COLS'(1) << hole_c) : '0;

`ifdef BOMB_EN
    localparam int unsigned CW = (BOMBS > 0) ? $clog2(BOMBS + 1) : 1;
    logic [CW-1:0] charges, charges_n;
    logic          bomb_prev;
    logic          bomb_led_n;

    assign bomb_fire_c = (state == ST_RUN) && bomb && !bomb_prev && (charges != '0);
`else
    logic unused_bomb;

    assign unused_bomb = bomb;
    assign bomb_fire_c = 1'b0;
    assign bomb_led    = 1'b0;
`endif

    // Next-state and game logic; start has priority in every state.
    always_comb begin
        state_n = state;
        field_n = field;
        cart_n  = cart;
        alive_n = alive;
        score_n = score;
        lives_n = lives;
        cnt_n   = cnt;
        wc_n    = wc;
        lfsr_n  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`ifdef BOMB_EN
        charges_n = charges;
`endif
        if (start) begin
            state_n = ST_RUN;
            field_n = '0;
            score_n = '0;
            alive_n = '1;
            cart_n  = {N_PLAYERS{CENTRE}};
            cnt_n   = '0;
            wc_n    = '0;
            for (int p = 0; p < int'(N_PLAYERS); p++) lives_n[p*LW +: LW] = LW'(LIVES);
`ifdef BOMB_EN
            charges_n = CW'(BOMBS);
`endif
        end else if (state == ST_RUN) begin
            if (bomb_fire_c) begin
                // Bomb beats a coincident tick: no hit evaluation, no scroll.
                field_n = '0;
                cnt_n   = '0;
`ifdef BOMB_EN
                charges_n = charges - CW'(1);
`endif
            end else if (tick_c) begin
                cnt_n = '0;
                // Hits use the registered (pre-move) cart positions.
                for (int p = 0; p < int'(N_PLAYERS); p++) begin
                    if (alive[p]) begin
                        if ((field[COLS-1:0] & cart[p*COLS +: COLS]) != '0) begin
                            lives_n[p*LW +: LW] = lives[p*LW +: LW] - LW'(1);
                            if (lives[p*LW +: LW] == LW'(1)) alive_n[p] = 1'b0;
                        end else if (field[COLS-1:0] != '0) begin
                            score_n[p*SW +: SW] = bcd_inc(score[p*SW +: SW]);
                        end
                    end
                end
                field_n = {top_c, field[FW-1 -: FW-COLS]};
                wc_n    = (wc == WW'(SPACING - 1)) ? '0 : wc + WW'(1);
            end else begin
                cnt_n = cnt + DW'(1);
            end
            for (int p = 0; p < int'(N_PLAYERS); p++) begin
                if (alive[p]) begin
                    if (rise_l_c[p] && !rise_r_c[p] && !cart[p*COLS + COLS - 1])
                        cart_n[p*COLS +: COLS] = cart[p*COLS +: COLS] << 1;
                    else if (rise_r_c[p] && !rise_l_c[p] && !cart[p*COLS])
                        cart_n[p*COLS +: COLS] = cart[p*COLS +: COLS] >> 1;
                end
            end
            if (alive_n == '0) state_n = ST_OVER;
        end else if (state != ST_IDLE && state != ST_OVER) begin
            state_n = ST_IDLE;
        end
`ifdef BOMB_EN
        bomb_led_n = (state_n == ST_RUN) && (charges_n != '0);
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            field  <= '0;
            cart   <= {N_PLAYERS{CENTRE}};
            alive  <= '0;
            score  <= '0;
            lives  <= '0;
            cnt    <= '0;
            wc     <= '0;
            lfsr   <= 16'hACE1;
            prev_l <= '0;
            prev_r <= '0;
        end else begin
            state  <= state_n;
            field  <= field_n;
            cart   <= cart_n;
            alive  <= alive_n;
            score  <= score_n;
            lives  <= lives_n;
            cnt    <= cnt_n;
            wc     <= wc_n;
            lfsr   <= lfsr_n;
            prev_l <= btn_l;
            prev_r <= btn_r;
        end
    end

`ifdef BOMB_EN
    // Bomb charge registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            charges   <= '0;
            bomb_prev <= 1'b0;
            bomb_led  <= 1'b0;
        end else begin
            charges   <= charges_n;
            bomb_prev <= bomb;
            bomb_led  <= bomb_led_n;
        end
    end
`endif

endmodule

// File: tb/tb_cart_race_core.sv
// Bench for cart_race_core: directed game scenarios plus random play, checked
// against a lane-index / decimal-score reference model of the game rules.
module tb_cart_race_core;

    localparam int NP = 2;
    localparam int C  = 8;
    localparam int R  = 4;
    localparam int BP = 8;
    localparam int SP = 2;
    localparam int LV = 2;
    localparam int SD = 3;
    localparam int BB = 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    level;
    logic [NP-1:0] btn_l;
    logic [NP-1:0] btn_r;
    logic          bomb;
    logic [R*C-1:0]    field;
    logic [NP*C-1:0]   cart;
    logic [NP-1:0]     alive;
    logic [NP*4*SD-1:0] score;
    logic [1:0]        state;
    logic              bomb_led;

    int checks = 0;
    int errors = 0;

    // reference model
    int        m_state;
    int        m_row [R];
    int        m_pos [NP];
    bit        m_alive [NP];
    int        m_lives [NP];
    int        m_score [NP];
    int        m_cnt, m_wc, m_charges, m_ticks;
    bit [15:0] m_lfsr;
    bit [NP-1:0] m_pl, m_pr;
    bit        m_pb;

    cart_race_core #(
        .N_PLAYERS(NP), .COLS(C), .ROWS(R), .LIVES(LV), .SCORE_DIGITS(SD),
        .BASE_PERIOD(BP), .SPACING(SP), .BOMBS(BB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .level(level),
        .btn_l(btn_l), .btn_r(btn_r), .bomb(bomb),
        .field(field), .cart(cart), .alive(alive), .score(score),
        .state(state), .bomb_led(bomb_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_wc = 0; m_charges = 0; m_ticks = 0;
        m_lfsr = 16'hACE1; m_pl = '0; m_pr = '0; m_pb = 0;
        for (int r = 0; r < R; r++) m_row[r] = 0;
        for (int p = 0; p < NP; p++) begin
            m_pos[p] = C / 2; m_alive[p] = 0; m_lives[p] = 0; m_score[p] = 0;
        end
    endtask

    task automatic model_entry();
        m_state = 1; m_cnt = 0; m_wc = 0; m_charges = BB;
        for (int r = 0; r < R; r++) m_row[r] = 0;
        for (int p = 0; p < NP; p++) begin
            m_pos[p] = C / 2; m_alive[p] = 1; m_lives[p] = LV; m_score[p] = 0;
        end
    endtask

    // One clock of game rules applied to the current inputs.
    task automatic model_step();
        bit [15:0] nl;
        int per;
        bit tk, bf, rl, rr, any;
        bit oa [NP];
        nl = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (start) begin
            model_entry();
        end else if (m_state == 1) begin
            per = BP >> level;
            if (per < 1) per = 1;
            tk = (m_cnt >= per - 1);
            bf = 0;
`ifdef BOMB_EN
            bf = bomb && !m_pb && (m_charges > 0);
`endif
            for (int p = 0; p < NP; p++) oa[p] = m_alive[p];
            if (bf) begin
                for (int r = 0; r < R; r++) m_row[r] = 0;
                m_cnt = 0;
                m_charges--;
            end else if (tk) begin
                m_cnt = 0;
                m_ticks++;
                for (int p = 0; p < NP; p++) begin
                    if (oa[p]) begin
                        if (((m_row[0] >> m_pos[p]) & 1) != 0) begin
                            m_lives[p]--;
                            if (m_lives[p] == 0) m_alive[p] = 0;
                        end else if (m_row[0] != 0 && m_score[p] < 999) begin
                            m_score[p]++;
                        end
                    end
                end
                for (int r = 0; r < R - 1; r++) m_row[r] = m_row[r+1];
                m_row[R-1] = (m_wc == 0) ? (255 & ~(1 << (int'(m_lfsr[7:0]) % C))) : 0;
                m_wc = (m_wc + 1) % SP;
            end else begin
                m_cnt++;
            end
            for (int p = 0; p < NP; p++) begin
                if (oa[p]) begin
                    rl = btn_l[p] && !m_pl[p];
                    rr = btn_r[p] && !m_pr[p];
                    if (rl && !rr && m_pos[p] < C - 1) m_pos[p]++;
                    else if (rr && !rl && m_pos[p] > 0) m_pos[p]--;
                end
            end
            any = 0;
            for (int p = 0; p < NP; p++) if (m_alive[p]) any = 1;
            if (!any) m_state = 2;
        end
        m_pl = btn_l; m_pr = btn_r; m_pb = bomb; m_lfsr = nl;
    endtask

    task automatic check_all(input string tag);
        logic [R*C-1:0]     ef;
        logic [NP*C-1:0]    ec;
        logic [NP-1:0]      ea;
        logic [NP*4*SD-1:0] es;
        logic               el;
        for (int r = 0; r < R; r++) ef[r*C +: C] = 8'(m_row[r]);
        for (int p = 0; p < NP; p++) begin
            ec[p*C +: C] = 8'(1 << m_pos[p]);
            ea[p] = m_alive[p];
            es[p*12 +: 12] = {4'(m_score[p] / 100), 4'((m_score[p] / 10) % 10), 4'(m_score[p] % 10)};
        end
`ifdef BOMB_EN
        el = (m_state == 1) && (m_charges > 0);
`else
        el = 1'b0;
`endif
        chk({tag, ".state"}, 64'(state), 64'(m_state));
        chk({tag, ".field"}, 64'(field), 64'(ef));
        chk({tag, ".cart"},  64'(cart),  64'(ec));
        chk({tag, ".alive"}, 64'(alive), 64'(ea));
        chk({tag, ".score"}, 64'(score), 64'(es));
        chk({tag, ".led"},   64'(bomb_led), 64'(el));
    endtask

    task automatic clk1(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic press(input int p, input bit left);
        if (left) btn_l[p] = 1'b1; else btn_r[p] = 1'b1;
        clk1("press");
        btn_l = '0; btn_r = '0;
        clk1("release");
    endtask

    task automatic move_to(input int p, input int target);
        for (int k = 0; k < C && m_pos[p] != target; k++) press(p, target > m_pos[p]);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = m_ticks + n;
        for (int g = 0; g < 200 && m_ticks < target; g++) clk1("wait");
        if (m_ticks < target) begin
            checks++;
            errors++;
            $error("FAIL wait_ticks bound expired ticks %0d required %0d", m_ticks, target);
        end
    endtask

    logic [R*C-1:0]     fz_field;
    logic [NP*C-1:0]    fz_cart;
    logic [NP*4*SD-1:0] fz_score;
    int hole;

    initial begin
        reset = 1'b0; start = 1'b0; level = 3'd0; btn_l = '0; btn_r = '0; bomb = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("rst_cart", 64'(cart), 64'h1010);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_alive", 64'(alive), 64'd0);
        reset = 1'b1;
        clk1("idle");
        clk1("idle");

        // first game: start, first wall on the 8th clock
        start = 1'b1; clk1("start"); start = 1'b0;
        chk("start_state", 64'(state), 64'd1);
        chk("start_cart", 64'(cart), 64'h1010);
        chk("start_alive", 64'(alive), 64'd3);
        repeat (7) clk1("prewall");
        chk("prewall_field", 64'(field), 64'd0);
        clk1("wall1");
        chk("wall1_bits", 64'($countones(field[31:24])), 64'd7);
        chk("wall1_low", 64'(field[23:0]), 64'd0);

        // player 0 onto the hole, player 1 on a wall bit
        hole = 0;
        for (int i = 0; i < C; i++) if (((m_row[R-1] >> i) & 1) == 0) hole = i;
        move_to(0, hole);
        if (hole == C / 2) move_to(1, C / 2 + 1);
        wait_ticks(5 - m_ticks);
        chk("eval_score0", 64'(score[11:0]), 64'h001);
        chk("eval_score1", 64'(score[23:12]), 64'h000);
        chk("eval_alive", 64'(alive), 64'd3);

        // restart while running, then saturate player 0 at the MSB lane
        start = 1'b1; clk1("restart"); start = 1'b0;
        chk("restart_score", 64'(score), 64'd0);
        repeat (5) press(0, 1'b1);
        chk("sat_cart0", 64'(cart[7:0]), 64'h80);
        btn_l = 2'b11; btn_r = 2'b11; clk1("simul");
        chk("simul_cart", 64'(cart), 64'h1080);
        btn_l = '0; btn_r = '0; clk1("simul_rel");

        // dodge nothing useful: step off holes until both players are out
        for (int g = 0; g < 600 && m_state == 1; g++) begin
            btn_l = '0; btn_r = '0;
            for (int p = 0; p < NP; p++) begin
                if (m_alive[p] && m_row[0] != 0 && ((m_row[0] >> m_pos[p]) & 1) == 0
                    && !m_pl[p] && !m_pr[p]) begin
                    if (m_pos[p] < C - 1) btn_l[p] = 1'b1; else btn_r[p] = 1'b1;
                end
            end
            clk1("die");
        end
        btn_l = '0; btn_r = '0;
        chk("over_state", 64'(state), 64'd2);
        chk("over_alive", 64'(alive), 64'd0);

        // frozen in OVER despite button activity
        fz_field = field; fz_cart = cart; fz_score = score;
        for (int k = 0; k < 100; k++) begin
            btn_l = NP'($urandom); btn_r = NP'($urandom); bomb = 1'($urandom);
            clk1("frozen");
            if (k % 25 == 24) begin
                chk("frozen_field", 64'(field), 64'(fz_field));
                chk("frozen_cart", 64'(cart), 64'(fz_cart));
                chk("frozen_score", 64'(score), 64'(fz_score));
            end
        end
        btn_l = '0; btn_r = '0; bomb = 1'b0;
        clk1("frozen_end");
        start = 1'b1; clk1("start2"); start = 1'b0;
        chk("start2_state", 64'(state), 64'd1);
        chk("start2_score", 64'(score), 64'd0);

        // level 3 and level 7 both give a tick every clock
        for (int lv = 3; lv <= 7; lv += 4) begin
            level = 3'(lv);
            start = 1'b1; clk1("fast_start"); start = 1'b0;
            clk1("fast1");
            chk("fast1_top", 64'($countones(field[31:24])), 64'd7);
            clk1("fast2");
            chk("fast2_top", 64'(field[31:24]), 64'd0);
            chk("fast2_row2", 64'($countones(field[23:16])), 64'd7);
        end
        level = 3'd0;

`ifdef BOMB_EN
        start = 1'b1; clk1("bomb_start"); start = 1'b0;
        chk("bomb_led_on", 64'(bomb_led), 64'd1);
        repeat (8) clk1("bomb_w");
        repeat (7) clk1("bomb_w");
        bomb = 1'b1; clk1("bomb_hit");
        chk("bomb_field", 64'(field), 64'd0);
        chk("bomb_score", 64'(score), 64'd0);
        chk("bomb_led_off", 64'(bomb_led), 64'd0);
        bomb = 1'b0; clk1("bomb_rel");
        bomb = 1'b1; clk1("bomb2");
        bomb = 1'b0;
        chk("bomb2_led", 64'(bomb_led), 64'd0);
        wait_ticks(2);
        chk("bomb2_wall", 64'($countones(field[31:24])), 64'd7);
`endif

        // random play
        for (int gm = 0; gm < 6; gm++) begin
            level = 3'($urandom_range(0, 3));
            start = 1'b1; clk1("rnd_start"); start = 1'b0;
            for (int k = 0; k < 300; k++) begin
                btn_l = NP'($urandom);
                btn_r = NP'($urandom);
                bomb  = ($urandom_range(0, 15) == 0);
                start = (m_state != 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 499) == 0);
                clk1("rnd");
            end
            start = 1'b0; btn_l = '0; btn_r = '0; bomb = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
